pixel_fifo: RTL and testbench
=============================

// Module: pixel_fifo
// PURPOSE
//  Pixel FIFO directly downstream of the UART pixel packer. It buffers the
//  24-bit RGB words delivered on the packer's pixel_ready strobe and counts
//  pixels per frame so that each stored word carries a start-of-frame tag.
//  A first-word-fall-through (FWFT) read port feeds the frame-buffer/VGA side.
//  The packer cannot stall, so a full FIFO drops writes and flags overflow.
// PARAMETERS
//  DATA_W        24      pixel word width {R,G,B}
//  DEPTH         1024    entries; power of two, >= 4
//  FRAME_PIXELS  76800   pixels per frame (320x240); >= 2
// PORTS
//  clk            in   1                 system clock
//  reset          in   1                 synchronous, active-high reset
//  pixel_ready    in   1                 write strobe, 1-cycle pulse from packer
//  RGB            in   DATA_W            pixel word, valid while pixel_ready=1
//  rd_en          in   1                 pop request; ignored while empty
//  clear_overflow in   1                 clears the sticky overflow flag
//  rd_data        out  DATA_W            head word; valid while empty=0
//  rd_sof         out  1                 head word is the first pixel of a frame
//  empty          out  1                 FIFO holds no words
//  full           out  1                 level == DEPTH
//  level          out  $clog2(DEPTH)+1   number of stored words
//  overflow       out  1                 sticky: a write was dropped
//  frame_done     out  1                 1-cycle pulse: last pixel of a frame was strobed
// BEHAVIOUR
//  - Reset values: empty=1, full=0, level=0, overflow=0, frame_done=0,
//    rd_data=0, rd_sof=0. Write/read pointers=0, pixel counter=0.
//    Reset mid-frame discards all contents; the next strobe is tagged sof.
//  - Storage: DEPTH x (DATA_W+1) array holding {sof_tag, RGB}. Pointers are
//    $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - Write: accepted when pixel_ready=1 and (full=0 or a pop happens in the
//    same cycle). An accepted word appears at the head on the next cycle if
//    the FIFO was empty, i.e. empty falls 1 cycle after the strobe.
//  - Drop: pixel_ready=1, full=1, no pop -> word discarded, overflow=1 from
//    the next cycle until clear_overflow=1 or reset. If clear_overflow and a
//    drop occur in the same cycle, set wins.
//  - Read (FWFT): rd_data/rd_sof show the head whenever empty=0. A pop occurs
//    when rd_en=1 and empty=0; the head advances on the next edge. rd_en with
//    empty=1 has no effect. When empty=1, rd_data and rd_sof hold their last
//    values (rd_sof=0 after reset).
//  - Simultaneous push+pop: the level is unchanged. At full, both succeed.
//    At empty, no pop occurs; the push proceeds.
//  - level: +1 on a push alone, -1 on a pop alone, otherwise unchanged.
//    full = (level==DEPTH). empty = (level==0).
//  - Frame counter: counts every pixel_ready strobe, including dropped ones,
//    so frame alignment tracks the sender. sof_tag = (counter==0). On the
//    strobe at counter==FRAME_PIXELS-1, the counter wraps to 0 and frame_done
//    pulses high for exactly 1 cycle, on the cycle after that strobe.
//  - Control FSM (level/flags): EMPTY -> PARTIAL on a push.
//    PARTIAL -> FULL when level reaches DEPTH.
//    PARTIAL -> EMPTY when level reaches 0.
//    FULL -> PARTIAL on a pop without a push.
//    Outputs empty and full decode directly from this state.
//  - Back-to-back strobes (every cycle) must be sustained; the packer emits at
//    most one word per 7 cycles, but the FIFO must not depend on that spacing.
// TESTING
//  1. reset; strobe RGB=24'hFF0000 once; rd_en=0 -> next cycle empty=0,
//     rd_data=FF0000, rd_sof=1, level=1.
//  2. Push 3 words A,B,C, then rd_en=1 for 3 cycles -> data order A,B,C,
//     level 3->0, empty=1 after the 3rd pop; a 4th rd_en leaves level=0.
//  3. Push DEPTH words -> full=1, level=1024. 1 extra strobe -> overflow=1,
//     level stays 1024. clear_overflow=1 -> overflow=0 next cycle.
//  4. At full: pixel_ready and rd_en in the same cycle -> level stays 1024,
//     overflow stays 0, head advances, new word stored at the tail.
//  5. FRAME_PIXELS=4: strobe 9 pixels -> rd_sof set on words 0, 4 and 8;
//     frame_done pulses after strobes 4 and 8.
//  6. Push 5 words, assert reset mid-frame -> empty=1, level=0; the next
//     strobe is read back with rd_sof=1.

Source files
------------

// File: rtl/pixel_fifo.sv
// Pixel FIFO behind the UART pixel packer: buffers {sof_tag, RGB} words with a
// first-word-fall-through read port and tags each word with start-of-frame.
module pixel_fifo #(
  parameter int DATA_W       = 24,
  parameter int DEPTH        = 1024,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pixel_ready,
  input  logic [DATA_W-1:0]      RGB,
  input  logic                   rd_en,
  input  logic                   clear_overflow,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_sof,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_PIXELS);
  localparam int EW = DATA_W + 1;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_pix_cnt;
  logic          r_overflow;
  logic          r_frame_done;
  logic [EW-1:0] r_head;
  state_t        r_state;

  state_t        w_state_nxt;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_sof;
  logic [LW-1:0] w_level_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [EW-1:0] w_head_nxt;

  // Control FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control FSM: next-state logic driven by the post-edge level
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) w_state_nxt = ST_PARTIAL;
        else        w_state_nxt = ST_EMPTY;
      end
      ST_PARTIAL: begin
        if (w_level_nxt == FULL_LVL)      w_state_nxt = ST_FULL;
        else if (w_level_nxt == LW'(0))   w_state_nxt = ST_EMPTY;
        else                              w_state_nxt = ST_PARTIAL;
      end
      ST_FULL: begin
        if (w_pop && !w_push) w_state_nxt = ST_PARTIAL;
        else                  w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Control FSM: empty/full decode
  always_comb begin
    w_empty = 1'b0;
    w_full  = 1'b0;
    case (r_state)
      ST_EMPTY:   w_empty = 1'b1;
      ST_PARTIAL: begin
        w_empty = 1'b0;
        w_full  = 1'b0;
      end
      ST_FULL:    w_full  = 1'b1;
      default:    w_empty = 1'b1;
    endcase
  end

  // Handshake decode; a pop frees the slot a same-cycle push needs at full
  always_comb begin
    w_pop  = rd_en && !w_empty;
    w_push = pixel_ready && (!w_full || w_pop);
    w_drop = pixel_ready && !w_push;
    w_sof  = (r_pix_cnt == CW'(0));
  end

  // Next level, next read pointer and the word that will sit at the head
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
    if (w_pop) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    else       w_rd_ptr_nxt = r_rd_ptr;
    // The new head may be the word being written this very cycle
    if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) w_head_nxt = {w_sof, RGB};
    else                                      w_head_nxt = r_mem[w_rd_ptr_nxt];
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_sof, RGB};
    end
  end

  // Pointers and level
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_level  <= LW'(0);
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
    end
  end

  // Registered FWFT head; holds its last value while the FIFO is empty
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= EW'(0);
    end else if (w_level_nxt != LW'(0)) begin
      r_head <= w_head_nxt;
    end
  end

  // Frame pixel counter counts dropped strobes too, to stay aligned with the sender
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_cnt    <= CW'(0);
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= pixel_ready && (r_pix_cnt == LAST_PIX);
      if (pixel_ready) begin
        if (r_pix_cnt == LAST_PIX) r_pix_cnt <= CW'(0);
        else                       r_pix_cnt <= r_pix_cnt + CW'(1);
      end
    end
  end

  // Sticky overflow; a drop wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign rd_data    = r_head[DATA_W-1:0];
  assign rd_sof     = r_head[DATA_W];
  assign empty      = w_empty;
  assign full       = w_full;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_fifo.sv
// Self-checking bench for pixel_fifo: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_pixel_fifo;

  localparam int DW    = 24;
  localparam int DEPTH = 1024;
  localparam int FP    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixel_ready;
  logic [DW-1:0] RGB;
  logic          rd_en;
  logic          clear_overflow;
  logic [DW-1:0] rd_data;
  logic          rd_sof;
  logic          empty;
  logic          full;
  logic [10:0]   level;
  logic          overflow;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW:0]   mq[$];
  int            m_cnt;
  logic          m_ovf;
  logic          m_fd;
  logic [DW-1:0] m_rd;
  logic          m_sof;

  pixel_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .reset(reset), .pixel_ready(pixel_ready), .RGB(RGB),
    .rd_en(rd_en), .clear_overflow(clear_overflow), .rd_data(rd_data),
    .rd_sof(rd_sof), .empty(empty), .full(full), .level(level),
    .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("empty",      32'(empty),      32'(mq.size() == 0));
    chk("full",       32'(full),       32'(mq.size() == DEPTH));
    chk("level",      32'(level),      32'(mq.size()));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("rd_data",    32'(rd_data),    32'(m_rd));
    chk("rd_sof",     32'(rd_sof),     32'(m_sof));
  endtask

  task automatic do_reset();
    reset = 1'b1; pixel_ready = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    m_cnt = 0; m_ovf = 1'b0; m_fd = 1'b0; m_rd = '0; m_sof = 1'b0;
    check_all();
  endtask

  task automatic step(input logic pr, input logic [DW-1:0] rgb, input logic re, input logic co);
    bit m_pop, m_push, m_drop, tag;
    pixel_ready = pr; RGB = rgb; rd_en = re; clear_overflow = co;
    m_pop  = re && (mq.size() != 0);
    m_push = pr && ((mq.size() != DEPTH) || m_pop);
    m_drop = pr && !m_push;
    tag    = (m_cnt == 0);
    m_fd   = pr && (m_cnt == FP - 1);
    if (pr) m_cnt = (m_cnt + 1) % FP;
    if (m_pop) void'(mq.pop_front());
    if (m_push) mq.push_back({tag, rgb});
    if (m_drop) m_ovf = 1'b1;
    else if (co) m_ovf = 1'b0;
    if (mq.size() != 0) begin
      m_sof = mq[0][DW];
      m_rd  = mq[0][DW-1:0];
    end
    @(posedge clk); #1;
    pixel_ready = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] w;
    int pr_bias, re_bias;
    reset = 1'b1; pixel_ready = 1'b0; RGB = '0; rd_en = 1'b0; clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);

    // 1: single strobe appears at the head one cycle later
    step(1'b1, 24'hFF0000, 1'b0, 1'b0);
    chk("t1_empty", 32'(empty),   32'd0);
    chk("t1_data",  32'(rd_data), 32'hFF0000);
    chk("t1_sof",   32'(rd_sof),  32'd1);
    chk("t1_level", 32'(level),   32'd1);

    // 2: order A,B,C then a pop on empty is ignored
    do_reset();
    step(1'b1, 24'h0000AA, 1'b0, 1'b0);
    step(1'b1, 24'h0000BB, 1'b0, 1'b0);
    step(1'b1, 24'h0000CC, 1'b0, 1'b0);
    chk("t2_level3", 32'(level), 32'd3);
    chk("t2_A", 32'(rd_data), 32'h0000AA);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("t2_B", 32'(rd_data), 32'h0000BB);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("t2_C", 32'(rd_data), 32'h0000CC);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("t2_empty", 32'(empty), 32'd1);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("t2_level0", 32'(level), 32'd0);
    chk("t2_hold", 32'(rd_data), 32'h0000CC);

    // 3: fill, overflow on extra strobe, then clear
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0);
    chk("t3_full",  32'(full),  32'd1);
    chk("t3_level", 32'(level), 32'd1024);
    step(1'b1, 24'h123456, 1'b0, 1'b0);
    chk("t3_ovf",   32'(overflow), 32'd1);
    chk("t3_level_keep", 32'(level), 32'd1024);
    step(1'b0, 24'h0, 1'b0, 1'b1);
    chk("t3_ovf_clr", 32'(overflow), 32'd0);

    // 4: push+pop at full, then drain to see the new tail word
    step(1'b1, 24'hABCDEF, 1'b1, 1'b0);
    chk("t4_level", 32'(level),    32'd1024);
    chk("t4_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("t4_tail", 32'(rd_data), 32'hABCDEF);

    // 5: frame tagging with FRAME_PIXELS=4
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 24'(k), 1'b0, 1'b0);
      chk("t5_fdone", 32'(frame_done), 32'((k == 4) || (k == 8)));
    end
    for (int i = 0; i < 9; i++) begin
      chk("t5_sof", 32'(rd_sof), 32'((i % 4) == 0));
      step(1'b0, 24'h0, 1'b1, 1'b0);
    end

    // 6: reset mid-frame
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 24'(i + 100), 1'b0, 1'b0);
    do_reset();
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_level", 32'(level), 32'd0);
    step(1'b1, 24'h00BEEF, 1'b0, 1'b0);
    chk("t6_sof", 32'(rd_sof), 32'd1);

    // Randomized traffic with shifting bias to visit empty, partial and full
    pr_bias = 60; re_bias = 50;
    for (int c = 0; c < 6000; c++) begin
      if ((c % 750) == 0) begin
        pr_bias = int'($urandom_range(10, 100));
        re_bias = int'($urandom_range(0, 90));
      end
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        w = 24'($urandom);
        step(1'($urandom_range(0, 99) < pr_bias), w,
             1'($urandom_range(0, 99) < re_bias),
             1'($urandom_range(0, 99) < 5));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
